// File: rtl/xbar_conn_ctrl_pkg.sv
// Shared constants, helpers and types for the crossbar connection controller.
package xbar_conn_ctrl_pkg;

  // Ceiling log2, used to size port indices from the port count.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      if ((32'd1 << k) < v) r = k + 1;
    end
    return r;
  endfunction

  localparam int unsigned N    = 12;
  localparam int unsigned LW   = 4;
  localparam int unsigned LOGN = clog2(N);

  // Flat bit position of grant/VOQ (i,j) in an N*N vector.
  function automatic int unsigned grant_idx(input int unsigned i, input int unsigned j);
    return i * N + j;
  endfunction

  typedef enum logic {
    PORT_IDLE = 1'b0,
    PORT_BUSY = 1'b1
  } port_state_e;

endpackage

// File: rtl/xbar_conn_ctrl_if.sv
// Scheduler <-> connection controller bus: grant inputs and crossbar/VOQ outputs.
interface xbar_conn_ctrl_if;
  import xbar_conn_ctrl_pkg::*;

  logic [N*N-1:0]    i_acc_grant;
  logic              i_grant_valid;
  logic [N*N*LW-1:0] i_pkt_len;
  logic [N-1:0]      o_input_idle;
  logic [N-1:0]      o_output_idle;
  logic [N*LOGN-1:0] o_xbar_sel;
  logic [N-1:0]      o_xbar_en;
  logic [N*N-1:0]    o_deq;
  logic [N-1:0]      o_cell_rd;
  logic              o_err;

  // Scheduler side.
  modport master (
    output i_acc_grant, i_grant_valid, i_pkt_len,
    input  o_input_idle, o_output_idle, o_xbar_sel, o_xbar_en, o_deq, o_cell_rd, o_err
  );

  // Controller side.
  modport slave (
    input  i_acc_grant, i_grant_valid, i_pkt_len,
    output o_input_idle, o_output_idle, o_xbar_sel, o_xbar_en, o_deq, o_cell_rd, o_err
  );

endinterface

// File: rtl/xbar_conn_ctrl_port_timer.sv
// Per-input connection timer: holds remaining cell count and the connected output.
module xbar_port_timer import xbar_conn_ctrl_pkg::*; (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [LW-1:0]   len_i,
  input  logic [LOGN-1:0] load_dst_i,
  output logic            busy_o,
  output logic            first_o,
  output logic [LOGN-1:0] dst_o
);

  logic [LW-1:0]   cnt_q, cnt_d;
  logic [LOGN-1:0] dst_q, dst_d;
  logic            first_q, first_d;
  port_state_e     state;

  // Port is busy exactly while cells remain.
  always_comb begin
    state = (cnt_q != '0) ? PORT_BUSY : PORT_IDLE;
  end

  // Load on accept (length 0 counts as one cell), otherwise count down to idle.
  always_comb begin
    cnt_d   = cnt_q;
    dst_d   = dst_q;
    first_d = 1'b0;
    if (load_i && (state == PORT_IDLE)) begin
      cnt_d   = (len_i == '0) ? LW'(1) : len_i;
      dst_d   = load_dst_i;
      first_d = 1'b1;
    end else if (state == PORT_BUSY) begin
      cnt_d = cnt_q - LW'(1);
    end
  end

  // Timer state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      dst_q   <= '0;
      first_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      dst_q   <= dst_d;
      first_q <= first_d;
    end
  end

  assign busy_o  = (state == PORT_BUSY);
  assign first_o = first_q;
  assign dst_o   = dst_q;

endmodule

// File: rtl/xbar_conn_ctrl.sv
// Crossbar connection controller: validates grant matrices, holds connections for the
// packet length and drives crossbar selects, VOQ strobes and the scheduler idle vectors.
module xbar_conn_ctrl import xbar_conn_ctrl_pkg::*; (
  input logic             clk,
  input logic             reset,
  xbar_conn_ctrl_if.slave bus
);

  logic [N-1:0]      busy;
  logic [N-1:0]      first;
  logic [N-1:0]      obusy;
  logic [N-1:0]      load;
  logic [LOGN-1:0]   dst      [N];
  logic [LOGN-1:0]   load_dst [N];
  logic [LW-1:0]     load_len [N];
  logic [N-1:0]      row_seen;
  logic [N-1:0]      col_seen;
  logic              conflict;
  logic [N*LOGN-1:0] sel;
  logic [N*N-1:0]    deq;
  logic              err_q, err_d;

  // Flag any row or column of the grant matrix with more than one bit set.
  always_comb begin
    conflict = 1'b0;
    row_seen = '0;
    col_seen = '0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (bus.i_acc_grant[grant_idx(i, j)]) begin
          if (row_seen[i] || col_seen[j]) conflict = 1'b1;
          row_seen[i] = 1'b1;
          col_seen[j] = 1'b1;
        end
      end
    end
  end

  // Accept clean grants whose input and output are both idle before this edge.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      load[i]     = 1'b0;
      load_dst[i] = '0;
      load_len[i] = '0;
      for (int unsigned j = 0; j < N; j++) begin
        if (bus.i_grant_valid && !conflict && bus.i_acc_grant[grant_idx(i, j)] &&
            !busy[i] && !obusy[j]) begin
          load[i]     = 1'b1;
          load_dst[i] = LOGN'(j);
          load_len[i] = bus.i_pkt_len[grant_idx(i, j)*LW +: LW];
        end
      end
    end
  end

  // Output-side view: busy reduction, select encoding and first-cell dequeue strobes.
  always_comb begin
    obusy = '0;
    sel   = '0;
    deq   = '0;
    for (int unsigned j = 0; j < N; j++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (busy[i] && (dst[i] == LOGN'(j))) begin
          obusy[j]              = 1'b1;
          sel[j*LOGN +: LOGN]   = LOGN'(i);
        end
        deq[grant_idx(i, j)] = first[i] && (dst[i] == LOGN'(j));
      end
    end
  end

  // Rejected matrix pulses the error flag for one cycle.
  always_comb begin
    err_d = bus.i_grant_valid && conflict;
  end

  // Error pulse register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_port
    xbar_port_timer u_timer (
      .clk_i      (clk),
      .rst_ni     (reset),
      .load_i     (load[gi]),
      .len_i      (load_len[gi]),
      .load_dst_i (load_dst[gi]),
      .busy_o     (busy[gi]),
      .first_o    (first[gi]),
      .dst_o      (dst[gi])
    );
  end

  assign bus.o_input_idle  = ~busy;
  assign bus.o_output_idle = ~obusy;
  assign bus.o_cell_rd     = busy;
  assign bus.o_xbar_en     = obusy;
  assign bus.o_xbar_sel    = sel;
  assign bus.o_deq         = deq;
  assign bus.o_err         = err_q;

endmodule

// File: tb/tb_xbar_conn_ctrl.sv
// Directed bench for the crossbar connection controller.
module tb_xbar_conn_ctrl;
  import xbar_conn_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  xbar_conn_ctrl_if bus ();

  xbar_conn_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.i_acc_grant   = '0;
    bus.i_grant_valid = 1'b0;
    bus.i_pkt_len     = '0;
  endtask

  task automatic add_grant(input int i, input int j, input int len);
    bus.i_acc_grant[i*N+j]         = 1'b1;
    bus.i_pkt_len[(i*N+j)*LW +: LW] = LW'(len);
  endtask

  // Present the prepared matrix as valid across one edge; afterwards we are in cycle 1.
  task automatic fire();
    bus.i_grant_valid = 1'b1;
    tick();
    clear_in();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_in();
    #12;
    n_cmp++; if (bus.o_input_idle !== 12'hfff) begin
      n_bad++; $display("FAIL reset_in_idle got %h want fff", bus.o_input_idle); end
    n_cmp++; if (bus.o_output_idle !== 12'hfff) begin
      n_bad++; $display("FAIL reset_out_idle got %h want fff", bus.o_output_idle); end
    n_cmp++; if (bus.o_xbar_en !== 12'h000 || bus.o_cell_rd !== 12'h000) begin
      n_bad++; $display("FAIL reset_en_rd got %h/%h want 0/0", bus.o_xbar_en, bus.o_cell_rd); end
    n_cmp++; if (bus.o_xbar_sel !== '0 || bus.o_deq !== '0 || bus.o_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_sel_deq_err got %h/%h/%b want 0", bus.o_xbar_sel,
                        bus.o_deq, bus.o_err); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [N*N-1:0] exp_deq;
    logic           act;
    add_grant(2, 5, 3);
    fire();
    for (int c = 1; c <= 4; c++) begin
      act     = (c <= 3);
      exp_deq = '0;
      if (c == 1) exp_deq[29] = 1'b1;
      n_cmp++; if (bus.o_deq !== exp_deq) begin
        n_bad++; $display("FAIL single_deq c=%0d got %h want %h", c, bus.o_deq, exp_deq); end
      n_cmp++; if (bus.o_cell_rd !== (act ? 12'h004 : 12'h000)) begin
        n_bad++; $display("FAIL single_rd c=%0d got %h", c, bus.o_cell_rd); end
      n_cmp++; if (bus.o_xbar_en !== (act ? 12'h020 : 12'h000)) begin
        n_bad++; $display("FAIL single_en c=%0d got %h", c, bus.o_xbar_en); end
      n_cmp++; if (bus.o_xbar_sel !== (act ? (48'd2 << 20) : 48'd0)) begin
        n_bad++; $display("FAIL single_sel c=%0d got %h", c, bus.o_xbar_sel); end
      n_cmp++; if (bus.o_input_idle !== (act ? 12'hffb : 12'hfff)) begin
        n_bad++; $display("FAIL single_in_idle c=%0d got %h", c, bus.o_input_idle); end
      n_cmp++; if (bus.o_output_idle !== (act ? 12'hfdf : 12'hfff)) begin
        n_bad++; $display("FAIL single_out_idle c=%0d got %h", c, bus.o_output_idle); end
      tick();
    end
  endtask

  task automatic test_conflict();
    add_grant(0, 1, 4);
    add_grant(3, 1, 4);
    fire();
    n_cmp++; if (bus.o_err !== 1'b1) begin
      n_bad++; $display("FAIL col_conflict_err got %b want 1", bus.o_err); end
    n_cmp++; if (bus.o_input_idle !== 12'hfff || bus.o_output_idle !== 12'hfff) begin
      n_bad++; $display("FAIL col_conflict_idle got %h/%h want fff/fff", bus.o_input_idle,
                        bus.o_output_idle); end
    tick();
    n_cmp++; if (bus.o_err !== 1'b0 || bus.o_cell_rd !== 12'h000) begin
      n_bad++; $display("FAIL col_conflict_after got err=%b rd=%h want 0/0", bus.o_err,
                        bus.o_cell_rd); end
    add_grant(0, 1, 4);
    add_grant(0, 2, 4);
    fire();
    n_cmp++; if (bus.o_err !== 1'b1 || bus.o_cell_rd !== 12'h000) begin
      n_bad++; $display("FAIL row_conflict got err=%b rd=%h want 1/0", bus.o_err,
                        bus.o_cell_rd); end
    tick();
    n_cmp++; if (bus.o_err !== 1'b0) begin
      n_bad++; $display("FAIL row_conflict_pulse got %b want 0", bus.o_err); end
  endtask

  task automatic test_busy_drop();
    logic [N*N-1:0] exp_deq;
    add_grant(1, 4, 5);
    fire();
    tick();
    tick();
    add_grant(1, 7, 2);
    add_grant(6, 4, 2);
    fire();
    n_cmp++; if (bus.o_err !== 1'b0) begin
      n_bad++; $display("FAIL drop_err got %b want 0", bus.o_err); end
    n_cmp++; if (bus.o_cell_rd !== 12'h002 || bus.o_xbar_en !== 12'h010) begin
      n_bad++; $display("FAIL drop_rd_en got %h/%h want 002/010", bus.o_cell_rd,
                        bus.o_xbar_en); end
    n_cmp++; if (bus.o_xbar_sel[4*LOGN +: LOGN] !== LOGN'(1)) begin
      n_bad++; $display("FAIL drop_sel got %0d want 1", bus.o_xbar_sel[4*LOGN +: LOGN]); end
    tick();
    n_cmp++; if (bus.o_cell_rd !== 12'h002) begin
      n_bad++; $display("FAIL drop_last got %h want 002", bus.o_cell_rd); end
    tick();
    n_cmp++; if (bus.o_cell_rd !== 12'h000 || bus.o_output_idle !== 12'hfff) begin
      n_bad++; $display("FAIL drop_release got %h/%h want 000/fff", bus.o_cell_rd,
                        bus.o_output_idle); end
    add_grant(6, 4, 2);
    fire();
    exp_deq     = '0;
    exp_deq[76] = 1'b1;
    n_cmp++; if (bus.o_cell_rd !== 12'h040 || bus.o_deq !== exp_deq) begin
      n_bad++; $display("FAIL regrant_rd_deq got %h/%h want 040/%h", bus.o_cell_rd,
                        bus.o_deq, exp_deq); end
    n_cmp++; if (bus.o_xbar_sel[4*LOGN +: LOGN] !== LOGN'(6)) begin
      n_bad++; $display("FAIL regrant_sel got %0d want 6", bus.o_xbar_sel[4*LOGN +: LOGN]); end
    tick();
    tick();
    n_cmp++; if (bus.o_input_idle !== 12'hfff) begin
      n_bad++; $display("FAIL regrant_done got %h want fff", bus.o_input_idle); end
  endtask

  task automatic test_boundary();
    add_grant(3, 3, 0);
    fire();
    n_cmp++; if (bus.o_cell_rd !== 12'h008) begin
      n_bad++; $display("FAIL len0_busy got %h want 008", bus.o_cell_rd); end
    tick();
    n_cmp++; if (bus.o_cell_rd !== 12'h000) begin
      n_bad++; $display("FAIL len0_release got %h want 000", bus.o_cell_rd); end
    add_grant(0, 0, 15);
    fire();
    for (int c = 1; c <= 17; c++) begin
      n_cmp++; if (bus.o_cell_rd[0] !== (c <= 15)) begin
        n_bad++; $display("FAIL len15 c=%0d got %b want %b", c, bus.o_cell_rd[0], (c <= 15)); end
      tick();
    end
    add_grant(7, 8, 2);
    fire();
    tick();
    add_grant(7, 9, 4);
    fire();
    n_cmp++; if (bus.o_cell_rd !== 12'h000 || bus.o_output_idle !== 12'hfff) begin
      n_bad++; $display("FAIL early_regrant got %h/%h want 000/fff", bus.o_cell_rd,
                        bus.o_output_idle); end
    add_grant(7, 9, 4);
    fire();
    n_cmp++; if (bus.o_cell_rd !== 12'h080 || bus.o_xbar_en !== 12'h200) begin
      n_bad++; $display("FAIL ontime_regrant got %h/%h want 080/200", bus.o_cell_rd,
                        bus.o_xbar_en); end
    n_cmp++; if (bus.o_xbar_sel[9*LOGN +: LOGN] !== LOGN'(7)) begin
      n_bad++; $display("FAIL ontime_sel got %0d want 7", bus.o_xbar_sel[9*LOGN +: LOGN]); end
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    logic [N*N-1:0] exp_deq;
    add_grant(0, 0, 3);
    fire();
    add_grant(1, 1, 3);
    fire();
    exp_deq     = '0;
    exp_deq[13] = 1'b1;
    n_cmp++; if (bus.o_cell_rd !== 12'h003 || bus.o_deq !== exp_deq) begin
      n_bad++; $display("FAIL b2b got rd=%h deq=%h want 003/%h", bus.o_cell_rd, bus.o_deq,
                        exp_deq); end
    repeat (3) tick();
    n_cmp++; if (bus.o_input_idle !== 12'hfff) begin
      n_bad++; $display("FAIL b2b_done got %h want fff", bus.o_input_idle); end
  endtask

  task automatic test_full_perm();
    int                lens [N] = '{1, 15, 3, 7, 2, 12, 5, 9, 4, 11, 6, 8};
    logic [N-1:0]      exp_act;
    logic [N*LOGN-1:0] exp_sel;
    logic [N*N-1:0]    exp_deq;
    for (int i = 0; i < N; i++) add_grant(i, i, lens[i]);
    fire();
    for (int c = 1; c <= 16; c++) begin
      exp_act = '0;
      exp_sel = '0;
      exp_deq = '0;
      for (int i = 0; i < N; i++) begin
        exp_act[i] = (c <= lens[i]);
        if (exp_act[i]) exp_sel[i*LOGN +: LOGN] = LOGN'(i);
        if (c == 1) exp_deq[i*N+i] = 1'b1;
      end
      n_cmp++; if (bus.o_cell_rd !== exp_act || bus.o_xbar_en !== exp_act) begin
        n_bad++; $display("FAIL perm_act c=%0d got %h/%h want %h", c, bus.o_cell_rd,
                          bus.o_xbar_en, exp_act); end
      n_cmp++; if (bus.o_xbar_sel !== exp_sel) begin
        n_bad++; $display("FAIL perm_sel c=%0d got %h want %h", c, bus.o_xbar_sel, exp_sel); end
      n_cmp++; if (bus.o_deq !== exp_deq) begin
        n_bad++; $display("FAIL perm_deq c=%0d got %h want %h", c, bus.o_deq, exp_deq); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    add_grant(4, 10, 10);
    fire();
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (bus.o_cell_rd !== 12'h000 || bus.o_xbar_en !== 12'h000) begin
      n_bad++; $display("FAIL mid_reset_rd_en got %h/%h want 0/0", bus.o_cell_rd,
                        bus.o_xbar_en); end
    n_cmp++; if (bus.o_input_idle !== 12'hfff || bus.o_output_idle !== 12'hfff) begin
      n_bad++; $display("FAIL mid_reset_idle got %h/%h want fff/fff", bus.o_input_idle,
                        bus.o_output_idle); end
    n_cmp++; if (bus.o_xbar_sel !== '0 || bus.o_deq !== '0 || bus.o_err !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_misc got %h/%h/%b want 0", bus.o_xbar_sel, bus.o_deq,
                        bus.o_err); end
    #1 reset = 1'b1;
    tick();
    n_cmp++; if (bus.o_cell_rd !== 12'h000) begin
      n_bad++; $display("FAIL post_reset_idle got %h want 000", bus.o_cell_rd); end
    add_grant(4, 10, 2);
    fire();
    n_cmp++; if (bus.o_cell_rd !== 12'h010 || bus.o_xbar_sel[10*LOGN +: LOGN] !== LOGN'(4)) begin
      n_bad++; $display("FAIL post_reset_grant got %h/%0d want 010/4", bus.o_cell_rd,
                        bus.o_xbar_sel[10*LOGN +: LOGN]); end
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_conflict();
    test_busy_drop();
    test_boundary();
    test_back_to_back();
    test_full_perm();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
